// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the block-wide data memory between the instruction
// cache refill port (0) and the data cache refill / write-back port (1).
// Whole-block transactions are serialised, and each one occupies the memory for
// MEM_LAT cycles.
// Optional feature: define MEMARB_RR_EN for round-robin tie breaking. When it is
// undefined, port 1 always wins simultaneous requests.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int BLK_W   = 1024,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [BLK_W-1:0]  wdata0,
    output logic              ack0,
    output logic [BLK_W-1:0]  rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [BLK_W-1:0]  wdata1,
    output logic              ack1,
    output logic [BLK_W-1:0]  rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [BLK_W-1:0]  mem_wdata,
    input  logic [BLK_W-1:0]  mem_rdata,
    output logic              busy
);

    // state | meaning
    // IDLE  | no transaction; requests sampled on every edge
    // BUSY  | memory access in flight, MEM_LAT cycles counted down in cnt
    // DONE  | ack pulse to the granted port; requests ignored
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [7:0] CNT_INIT = 8'(MEM_LAT - 1);

    logic [1:0] state;
    logic [7:0] cnt;
    logic       grant;
    logic       win;

`ifdef MEMARB_RR_EN
    logic rr_last;

    // On a tie, the port that did not win last time is served; a lone request always wins.
    always_comb begin
        if (req0 && req1) begin
            win = ~rr_last;
        end else begin
            win = req1;
        end
    end

    // Remember the most recent winner so that ties alternate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (state == IDLE && (req0 || req1)) begin
            rr_last <= win;
        end
    end
`else
    // Port 1 holds fixed priority; port 0 wins only when it requests alone.
    always_comb win = req1;
`endif

    // Transaction sequencer: grant, count the memory latency, capture read data, then ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            grant     <= 1'b0;
            busy      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant <= win;
                        busy  <= 1'b1;
                        cnt   <= CNT_INIT;
                        state <= BUSY;
                        if (win) begin
                            mem_addr  <= addr1;
                            mem_wdata <= wdata1;
                            mem_rd    <= ~we1;
                            mem_wr    <= we1;
                        end else begin
                            mem_addr  <= addr0;
                            mem_wdata <= wdata0;
                            mem_rd    <= ~we0;
                            mem_wr    <= we0;
                        end
                    end
                end
                BUSY: begin
                    mem_wr <= 1'b0;
                    if (cnt == 8'd0) begin
                        mem_rd <= 1'b0;
                        // mem_rd is still high here only for a read transaction
                        if (mem_rd) begin
                            if (grant) begin
                                rdata1 <= mem_rdata;
                            end else begin
                                rdata0 <= mem_rdata;
                            end
                        end
                        if (grant) begin
                            ack1 <= 1'b1;
                        end else begin
                            ack0 <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (MEM_LAT=4 and MEM_LAT=1) driven by directed
// and random requesters. A transaction-level model predicts every cycle's outputs.
module tb_mem_port_arbiter;

    localparam int AW   = 16;
    localparam int BW   = 64;
    localparam int LAT0 = 4;
    localparam int LAT1 = 1;
    localparam logic [BW-1:0] PAT = 64'hA5A5_5A5A_0F0F_F0F0;

    logic clk;
    logic rst_n;

    logic          rq   [2][2];
    logic          wen  [2][2];
    logic [AW-1:0] ad   [2][2];
    logic [BW-1:0] wd   [2][2];
    logic          ack  [2][2];
    logic [BW-1:0] rd   [2][2];
    logic [AW-1:0] m_addr  [2];
    logic          m_rd    [2];
    logic          m_wr    [2];
    logic          bsy     [2];
    logic [BW-1:0] m_wdata [2];
    logic [BW-1:0] m_rdata [2];

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_W(AW), .BLK_W(BW), .MEM_LAT(LAT0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req0(rq[0][0]), .we0(wen[0][0]), .addr0(ad[0][0]), .wdata0(wd[0][0]),
        .ack0(ack[0][0]), .rdata0(rd[0][0]),
        .req1(rq[0][1]), .we1(wen[0][1]), .addr1(ad[0][1]), .wdata1(wd[0][1]),
        .ack1(ack[0][1]), .rdata1(rd[0][1]),
        .mem_addr(m_addr[0]), .mem_rd(m_rd[0]), .mem_wr(m_wr[0]),
        .mem_wdata(m_wdata[0]), .mem_rdata(m_rdata[0]), .busy(bsy[0])
    );

    mem_port_arbiter #(.ADDR_W(AW), .BLK_W(BW), .MEM_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0(rq[1][0]), .we0(wen[1][0]), .addr0(ad[1][0]), .wdata0(wd[1][0]),
        .ack0(ack[1][0]), .rdata0(rd[1][0]),
        .req1(rq[1][1]), .we1(wen[1][1]), .addr1(ad[1][1]), .wdata1(wd[1][1]),
        .ack1(ack[1][1]), .rdata1(rd[1][1]),
        .mem_addr(m_addr[1]), .mem_rd(m_rd[1]), .mem_wr(m_wr[1]),
        .mem_wdata(m_wdata[1]), .mem_rdata(m_rdata[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [AW:0] key(input int d, input logic [AW-1:0] a);
        return {(d == 1), a};
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i);
        case (i)
            0:       return 16'h0400;
            1:       return 16'h0C00;
            2:       return 16'h0800;
            default: return 16'h1000;
        endcase
    endfunction

    // Memory contents: "store" is the memory the DUTs actually write and read;
    // "ref_mem" is what the model believes the memory holds.
    logic [BW-1:0] store   [logic [AW:0]];
    logic [BW-1:0] ref_mem [logic [AW:0]];

    // Transaction-level model: one outstanding transaction per arbiter,
    // described by its grant edge, port, direction, address and data.
    int            lat_of [2] = '{LAT0, LAT1};
    int            cyc = 0;
    bit            act    [2] = '{1'b0, 1'b0};
    int            g      [2];
    bit            gp     [2];
    bit            gwe    [2];
    logic [AW-1:0] gaddr  [2];
    logic [BW-1:0] gwdata [2];
    bit            rr     [2] = '{1'b1, 1'b1};
    logic [BW-1:0] exp_rd [2][2];

    // Model update at each clock edge; a grant occupies edges g .. g+L+1.
    always @(posedge clk or negedge rst_n) begin
        bit was;
        bit w;
        int L;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                act[d]       = 1'b0;
                rr[d]        = 1'b1;
                exp_rd[d][0] = '0;
                exp_rd[d][1] = '0;
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                L   = lat_of[d];
                was = act[d];
                if (was && cyc == g[d] + L && !gwe[d]) exp_rd[d][gp[d]] = ref_mem[key(d, gaddr[d])];
                if (was && cyc == g[d] + L + 1) act[d] = 1'b0;
                if (!was && (rq[d][0] || rq[d][1])) begin
                    if (rq[d][0] && rq[d][1]) begin
`ifdef MEMARB_RR_EN
                        w = (rr[d] == 1'b1) ? 1'b0 : 1'b1;
`else
                        w = 1'b1;
`endif
                    end else begin
                        w = rq[d][1];
                    end
                    rr[d]     = w;
                    act[d]    = 1'b1;
                    g[d]      = cyc;
                    gp[d]     = w;
                    gwe[d]    = wen[d][w];
                    gaddr[d]  = ad[d][w];
                    gwdata[d] = wd[d][w];
                    if (gwe[d]) ref_mem[key(d, gaddr[d])] = gwdata[d];
                end
            end
        end
    end

    // Check every output mid-cycle, apply memory writes, and drive read data
    // only during the final BUSY cycle; outside it the read bus carries garbage.
    always @(negedge clk) begin
        int L;
        bit in_busy;
        bit in_done;
        for (int d = 0; d < 2; d++) begin
            L       = lat_of[d];
            in_busy = act[d] && cyc >= g[d] && cyc <= g[d] + L - 1;
            in_done = act[d] && cyc == g[d] + L;
            chk($sformatf("d%0d_busy", d),   BW'(bsy[d]),    BW'(in_busy || in_done));
            chk($sformatf("d%0d_mem_rd", d), BW'(m_rd[d]),   BW'(in_busy && !gwe[d]));
            chk($sformatf("d%0d_mem_wr", d), BW'(m_wr[d]),   BW'(in_busy && gwe[d] && cyc == g[d]));
            chk($sformatf("d%0d_ack0", d),   BW'(ack[d][0]), BW'(in_done && !gp[d]));
            chk($sformatf("d%0d_ack1", d),   BW'(ack[d][1]), BW'(in_done && gp[d]));
            chk($sformatf("d%0d_rdata0", d), rd[d][0], exp_rd[d][0]);
            chk($sformatf("d%0d_rdata1", d), rd[d][1], exp_rd[d][1]);
            if (in_busy) chk($sformatf("d%0d_mem_addr", d), BW'(m_addr[d]), BW'(gaddr[d]));
            if (in_busy && gwe[d] && cyc == g[d]) chk($sformatf("d%0d_mem_wdata", d), m_wdata[d], gwdata[d]);
            if (m_wr[d]) store[key(d, m_addr[d])] = m_wdata[d];
            if (in_busy && !gwe[d] && cyc == g[d] + L - 1 && store.exists(key(d, gaddr[d])))
                m_rdata[d] = store[key(d, gaddr[d])];
            else
                m_rdata[d] = {$urandom, $urandom};
        end
    end

    // One whole request: raise at a negedge, wait (bounded) for ack, drop req.
    // lat counts negedges from the raise to the one that sees ack.
    task automatic do_req(input int d, input int p, input bit we_v, input logic [AW-1:0] a,
                          input logic [BW-1:0] w, output int lat);
        @(negedge clk);
        wen[d][p] = we_v;
        ad[d][p]  = a;
        wd[d][p]  = w;
        rq[d][p]  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack[d][p] && lat < 60);
        chk($sformatf("d%0d_p%0d_ack_seen", d, p), BW'(ack[d][p]), BW'(1'b1));
        rq[d][p] = 1'b0;
    endtask

    task automatic run_port(input int d, input int p, input int n);
        int lat;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            do_req(d, p, 1'($urandom_range(0, 1)), addr_of($urandom_range(0, 3)),
                   {$urandom, $urandom}, lat);
        end
    endtask

    initial begin
        int lat;
        int l0;
        int l1;
        logic [BW-1:0] v;
        for (int d = 0; d < 2; d++) begin
            m_rdata[d] = '0;
            for (int p = 0; p < 2; p++) begin
                rq[d][p] = 1'b0; wen[d][p] = 1'b0; ad[d][p] = '0; wd[d][p] = '0;
            end
            for (int i = 0; i < 4; i++) begin
                v = {$urandom, $urandom};
                store[key(d, addr_of(i))]   = v;
                ref_mem[key(d, addr_of(i))] = v;
            end
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_mem_addr", d), BW'(m_addr[d]), '0);
            chk($sformatf("d%0d_rst_mem_wdata", d), m_wdata[d], '0);
        end
        rst_n = 1'b1;

        // read on port 0, MEM_LAT=4
        do_req(0, 0, 1'b0, 16'h0400, '0, lat);
        chk("t2_read_lat", BW'(lat), BW'(5));
        chk("t2_rdata0", rd[0][0], ref_mem[key(0, 16'h0400)]);
        // write on port 1, then read it back
        do_req(0, 1, 1'b1, 16'h0C00, PAT, lat);
        chk("t3_write_lat", BW'(lat), BW'(5));
        do_req(0, 1, 1'b0, 16'h0C00, '0, lat);
        chk("t3_readback", rd[0][1], PAT);
        // simultaneous requests
        fork
            do_req(0, 0, 1'b0, 16'h0800, '0, l0);
            do_req(0, 1, 1'b0, 16'h1000, '0, l1);
        join
`ifdef MEMARB_RR_EN
        chk("t4_tie_lat0", BW'(l0), BW'(5));
        chk("t4_tie_lat1", BW'(l1), BW'(11));
`else
        chk("t4_tie_lat1", BW'(l1), BW'(5));
        chk("t4_tie_lat0", BW'(l0), BW'(11));
`endif
        // MEM_LAT=1: single BUSY cycle, back-to-back on one port
        do_req(1, 0, 1'b0, 16'h0400, '0, lat);
        chk("t5_lat1_read", BW'(lat), BW'(2));
        do_req(1, 0, 1'b0, 16'h0800, '0, lat);
        chk("t5_b2b_read", BW'(lat), BW'(2));
        do_req(1, 1, 1'b1, 16'h0C00, PAT, lat);
        chk("t5_lat1_write", BW'(lat), BW'(2));
        do_req(1, 1, 1'b0, 16'h0C00, '0, lat);
        chk("t5_readback", rd[1][1], PAT);
        fork
            do_req(1, 0, 1'b0, 16'h1000, '0, l0);
            do_req(1, 1, 1'b0, 16'h0400, '0, l1);
        join
`ifdef MEMARB_RR_EN
        chk("t5_tie_lat0", BW'(l0), BW'(2));
        chk("t5_tie_lat1", BW'(l1), BW'(5));
`else
        chk("t5_tie_lat1", BW'(l1), BW'(2));
        chk("t5_tie_lat0", BW'(l0), BW'(5));
`endif

        // reset in the middle of a read
        @(negedge clk);
        wen[0][0] = 1'b0; ad[0][0] = 16'h0400; rq[0][0] = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_arst_busy", d),   BW'(bsy[d]),    '0);
            chk($sformatf("d%0d_arst_mem_rd", d), BW'(m_rd[d]),   '0);
            chk($sformatf("d%0d_arst_addr", d),   BW'(m_addr[d]), '0);
            chk($sformatf("d%0d_arst_wdata", d),  m_wdata[d],     '0);
            chk($sformatf("d%0d_arst_rdata0", d), rd[d][0],       '0);
            chk($sformatf("d%0d_arst_rdata1", d), rd[d][1],       '0);
        end
        rq[0][0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("t1_no_ack_after_abort", BW'(ack[0][0]), '0);
        end

        // random traffic on both arbiters
        fork
            run_port(0, 0, 30);
            run_port(0, 1, 30);
            run_port(1, 0, 30);
            run_port(1, 1, 30);
        join
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
